mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 15 +
 rtl/byte_ram.sv | 31 +++
 rtl/mem_responder.sv | 121 ++++++++++++
 tb/tb_mem_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared state encoding and widths for the word-oriented memory responder.
package mem_pkg;

   localparam int unsigned DEF_ADDR_W = 8;
   localparam int unsigned WORD_W     = 16;
   localparam int unsigned BYTE_W     = 8;

   typedef enum logic [1:0] {
      IDLE,
      LO,
      HI,
      RESP
   } state_t;

endpackage

// File: rtl/byte_ram.sv
// Single-port byte storage: synchronous write, registered read, no reset on contents.
module byte_ram
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W
)
(
   input  logic              clk,
   input  logic              i_en,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [BYTE_W-1:0] i_wdata,
   output logic [BYTE_W-1:0] o_rdata
);

   logic [BYTE_W-1:0] r_mem [2**ADDR_W];
   logic [BYTE_W-1:0] r_rdata;

   // Read register only moves when enabled, so the last byte read stays visible.
   always_ff @(posedge clk) begin
      if (i_en) begin
         if (i_we) begin
            r_mem[i_addr] <= i_wdata;
         end
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Request/response front end that splits 16-bit word accesses into two byte accesses.
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [WORD_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [WORD_W-1:0] resp_rdata,
   output logic              resp_err
);

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [WORD_W-1:0] r_wdata;
   logic              r_write;
   logic              r_err;
   logic [BYTE_W-1:0] r_lo;

   logic              w_accept;
   logic              w_oor;
   logic              w_ram_en;
   logic              w_ram_we;
   logic [ADDR_W-1:0] w_ram_addr;
   logic [BYTE_W-1:0] w_ram_wdata;
   logic [BYTE_W-1:0] w_ram_rdata;

   assign w_accept = req_valid && req_ready;
   assign w_oor    = (req_addr >> ADDR_W) != '0;

   byte_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .i_en    (w_ram_en),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_addr),
      .i_wdata (w_ram_wdata),
      .o_rdata (w_ram_rdata)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_write <= 1'b0;
         r_err   <= 1'b0;
         r_lo    <= '0;
      end else begin
         if (w_accept) begin
            r_addr  <= req_addr[ADDR_W-1:0];
            r_wdata <= req_wdata;
            r_write <= req_write;
            r_err   <= w_oor;
         end
         // During HI the RAM output still shows the low byte fetched in LO.
         if (r_state == HI) begin
            r_lo <= w_ram_rdata;
         end
      end
   end

   always_comb begin
      w_next      = r_state;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      w_ram_en    = 1'b0;
      w_ram_we    = 1'b0;
      w_ram_addr  = r_addr;
      w_ram_wdata = r_wdata[BYTE_W-1:0];
      case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_next = w_oor ? RESP : LO;
            end
         end
         LO: begin
            w_ram_en = 1'b1;
            w_ram_we = r_write;
            w_next   = HI;
         end
         HI: begin
            w_ram_en    = 1'b1;
            w_ram_we    = r_write;
            w_ram_addr  = r_addr + ADDR_W'(1);
            w_ram_wdata = r_wdata[WORD_W-1:BYTE_W];
            w_next      = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // RAM read port is idle in RESP, so the high byte holds until the response is taken.
   assign resp_rdata = (r_state == RESP && !r_write && !r_err) ? {w_ram_rdata, r_lo} : '0;
   assign resp_err   = (r_state == RESP) && r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: reference byte model, queued expected responses.
module tb_mem_responder;

   localparam int unsigned AW = 8;

   logic        clk        = 1'b0;
   logic        reset_n    = 1'b0;
   logic        req_valid  = 1'b0;
   logic        req_write  = 1'b0;
   logic [15:0] req_addr   = '0;
   logic [15:0] req_wdata  = '0;
   logic        resp_ready = 1'b1;
   logic        req_ready;
   logic        resp_valid;
   logic [15:0] resp_rdata;
   logic        resp_err;

   mem_responder #(
      .ADDR_W (AW)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t       q[$];
   logic [7:0] model [256];
   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc      = 0;
   int         acc_cyc  = 0;
   int         idle_cyc = 0;
   int         n_issued = 0;
   int         n_resp   = 0;
   bit         b2b_on   = 1'b0;
   bit         prev_valid = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Response monitor: latency on first sight, data/err every RESP cycle, pop on handshake.
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_valid = 1'b0;
      end else begin
         if (req_valid && req_ready) begin
            acc_cyc = cyc + 1;
            if (b2b_on) chk("b2b_accept_gap", acc_cyc, idle_cyc + 1);
         end
         if (resp_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_resp", 1, 0);
            end else begin
               chk("req_ready_in_resp", req_ready, 0);
               if (!prev_valid) chk("latency", cyc - acc_cyc + 1, q[0].lat);
               chk("resp_rdata", resp_rdata, q[0].rdata);
               chk("resp_err", resp_err, q[0].err);
               if (resp_ready) begin
                  void'(q.pop_front());
                  idle_cyc = cyc + 1;
                  n_resp++;
               end
            end
         end
         prev_valid = resp_valid;
      end
   end

   task automatic issue(input logic wr, input logic [15:0] a, input logic [15:0] d, input bit hold);
      exp_t       e;
      int         n;
      logic [7:0] lo;
      logic [7:0] hi;
      @(posedge clk);
      #1;
      req_write = wr;
      req_addr  = a;
      req_wdata = d;
      req_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!req_ready) begin
         n++;
         if (n > 200) begin
            chk("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      @(posedge clk);
      lo = a[7:0];
      hi = lo + 8'd1;
      e.err = (a >> AW) != 16'd0;
      e.lat = e.err ? 1 : 3;
      e.rdata = '0;
      if (!e.err) begin
         if (wr) begin
            model[lo] = d[7:0];
            model[hi] = d[15:8];
         end else begin
            e.rdata = {model[hi], model[lo]};
         end
      end
      q.push_back(e);
      n_issued++;
      #1;
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain", q.size(), 0);
      @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_resp_err", resp_err, 0);
      reset_n = 1'b1;

      for (int unsigned i = 0; i < 256; i += 2) begin
         issue(1'b1, 16'(i), 16'($urandom), 1'b0);
      end
      drain();

      // Basic write then read back
      issue(1'b1, 16'h0010, 16'hBEEF, 1'b0);
      issue(1'b0, 16'h0010, 16'h0000, 1'b0);
      // Top-address wrap
      issue(1'b1, 16'h00FF, 16'h1234, 1'b0);
      issue(1'b0, 16'h0000, 16'h0000, 1'b0);
      issue(1'b0, 16'h00FE, 16'h0000, 1'b0);
      // Out of range: no error-aliased access into low addresses
      issue(1'b0, 16'h0100, 16'h0000, 1'b0);
      issue(1'b1, 16'h0105, 16'hFFFF, 1'b0);
      issue(1'b1, 16'h8004, 16'hFFFF, 1'b0);
      issue(1'b0, 16'h0004, 16'h0000, 1'b0);
      drain();

      // Response stall with an ignored request pulse
      resp_ready = 1'b0;
      issue(1'b0, 16'h0010, 16'h0000, 1'b0);
      n = 0;
      while (!resp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("stall_resp_seen", resp_valid, 1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         if (i == 1) begin
            req_write = 1'b1;
            req_addr  = 16'h0030;
            req_wdata = 16'hDEAD;
            req_valid = 1'b1;
         end else begin
            req_valid = 1'b0;
         end
      end
      @(negedge clk);
      chk("stall_still_valid", resp_valid, 1);
      resp_ready = 1'b1;
      drain();
      issue(1'b0, 16'h0030, 16'h0000, 1'b0);
      drain();

      // Reset while in HI of a write
      issue(1'b1, 16'h0020, 16'h1111, 1'b0);
      drain();
      @(posedge clk);
      #1;
      req_write = 1'b1;
      req_addr  = 16'h0020;
      req_wdata = 16'hA5C3;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("rst_hi_req_ready", req_ready, 1);
      chk("rst_hi_resp_valid", resp_valid, 0);
      @(negedge clk);
      reset_n = 1'b1;
      model[8'h20] = 8'hC3;
      repeat (4) @(negedge clk);
      issue(1'b0, 16'h0020, 16'h0000, 1'b0);
      drain();

      // Back-to-back reads with req_valid held high
      issue(1'b0, 16'h0010, 16'h0000, 1'b1);
      b2b_on = 1'b1;
      issue(1'b0, 16'h0020, 16'h0000, 1'b1);
      issue(1'b0, 16'h00FF, 16'h0000, 1'b1);
      issue(1'b0, 16'h0100, 16'h0000, 1'b1);
      issue(1'b0, 16'h0004, 16'h0000, 1'b0);
      b2b_on = 1'b0;
      drain();

      // Random mix
      for (int i = 0; i < 40; i++) begin
         logic [15:0] a;
         a = ($urandom_range(0, 7) == 0) ? 16'($urandom) | 16'h0100 : 16'($urandom_range(0, 255));
         issue(1'($urandom), a, 16'($urandom), 1'($urandom));
      end
      req_valid = 1'b0;
      drain();

      chk("resp_count", n_resp, n_issued);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
